// File: rtl/routesched.sv
// routesched: round-robin scheduler sharing the routing table's single
// destination-lookup port among NETH per-interface requesters.
// Each lookup result goes back only to the requester that asked for it.
// Build option: define ROUTESCHED_NOREFLECT_EN to remove the requester's own
// port from the returned mask, so a packet is never sent back out the port
// it arrived on.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no lookup in flight; arbitrate among S_VALID from rr
// LOOKUP   | M_VALID held with latched MAC, waiting for M_ACK
// RESPOND  | S_READY/S_PORT/S_DROP visible; advance rr and re-arbitrate
module routesched #(
    parameter int NETH = 4,
    parameter int MACW = 48
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NETH-1:0]      S_VALID,
    output logic [NETH-1:0]      S_READY,
    input  logic [NETH*MACW-1:0] S_DSTMAC,
    output logic [NETH-1:0]      S_PORT,
    output logic                 S_DROP,
    output logic                 M_VALID,
    input  logic                 M_ACK,
    output logic [MACW-1:0]      M_DSTMAC,
    input  logic [NETH-1:0]      M_PORT
);

    localparam int IW = (NETH > 1) ? $clog2(NETH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [IW-1:0]     r_rr;
    logic [IW-1:0]     r_gidx;
    logic [NETH-1:0]   r_res;
    logic [NETH-1:0]   r_s_ready;
    logic              r_s_drop;
    logic              r_m_valid;
    logic [MACW-1:0]   r_m_dstmac;

    logic [MACW-1:0]   w_mac [NETH];
    logic [IW-1:0]     w_gidx_inc;
    logic [NETH-1:0]   w_gbit;
    logic [NETH-1:0]   w_port_final;
    logic [IW-1:0]     w_arb_ptr;
    logic [NETH-1:0]   w_arb_req;
    logic              w_gnt_found;
    logic [IW-1:0]     w_gnt_idx;
    logic [IW:0]       w_sum;
    logic [IW-1:0]     w_cand;
    logic              w_load;
    logic              w_capture;

    for (genvar k = 0; k < NETH; k++) begin : g_mac
        assign w_mac[k] = S_DSTMAC[k*MACW +: MACW];
    end

    assign w_gidx_inc = (r_gidx == IW'(NETH - 1)) ? '0 : r_gidx + IW'(1);
    assign w_gbit     = NETH'(1) << r_gidx;

`ifdef ROUTESCHED_NOREFLECT_EN
    assign w_port_final = M_PORT & ~w_gbit;
`else
    assign w_port_final = M_PORT;
`endif

    // Arbitration inputs: in RESPOND the pointer already counts as advanced,
    // and the request being consumed this cycle must not win again.
    always_comb begin
        w_arb_ptr = r_rr;
        w_arb_req = S_VALID;
        if (r_state == ST_RESPOND) begin
            w_arb_ptr = w_gidx_inc;
            w_arb_req = S_VALID & ~r_s_ready;
        end
    end

    // First set request at or after the pointer, searching upward with wrap.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int i = 0; i < NETH; i++) begin
            w_sum = {1'b0, w_arb_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(NETH)) begin
                w_sum = w_sum - (IW+1)'(NETH);
            end
            w_cand = w_sum[IW-1:0];
            if (!w_gnt_found && w_arb_req[w_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_found) begin
                    w_load       = 1'b1;
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (M_ACK) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (w_gnt_found) begin
                    w_load       = 1'b1;
                    w_next_state = ST_LOOKUP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant latch, lookup request, and one-cycle registered response.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rr       <= '0;
            r_gidx     <= '0;
            r_res      <= '0;
            r_s_ready  <= '0;
            r_s_drop   <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_dstmac <= '0;
        end else begin
            r_s_ready <= '0;
            r_res     <= '0;
            r_s_drop  <= 1'b0;
            if (w_load) begin
                r_gidx     <= w_gnt_idx;
                r_m_dstmac <= w_mac[w_gnt_idx];
                r_m_valid  <= 1'b1;
            end
            if (w_capture) begin
                r_m_valid <= 1'b0;
                // A requester that withdrew during the lookup gets nothing.
                if (S_VALID[r_gidx]) begin
                    r_s_ready <= w_gbit;
                    r_res     <= w_port_final;
                    r_s_drop  <= (w_port_final == '0);
                end
            end
            if (r_state == ST_RESPOND) begin
                r_rr <= w_gidx_inc;
            end
        end
    end

    assign S_READY  = r_s_ready;
    assign S_PORT   = r_res;
    assign S_DROP   = r_s_drop;
    assign M_VALID  = r_m_valid;
    assign M_DSTMAC = r_m_dstmac;

endmodule
